// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO block with edge/level interrupts
// Optional per-input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_1000,
    parameter int          NUM_BIDIR = 4,
    parameter int          NUM_OUT   = 8,
    parameter int          NUM_IN    = 8,
    parameter int          DB_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic                 mem_we,
    input  logic                 mem_re,
    output logic [31:0]          mem_rdata,
    input  logic [NUM_BIDIR-1:0] gpio_bidir_in,
    output logic [NUM_BIDIR-1:0] gpio_bidir_out,
    output logic [NUM_BIDIR-1:0] gpio_bidir_oe,
    output logic [NUM_OUT-1:0]   gpio_out,
    input  logic [NUM_IN-1:0]    gpio_in,
    output logic                 gpio_interrupt
);

    localparam int INW  = NUM_BIDIR + NUM_IN;
    localparam int OUTW = NUM_BIDIR + NUM_OUT;

    localparam logic [7:0] OFF_DIR       = 8'h00;
    localparam logic [7:0] OFF_OUT       = 8'h04;
    localparam logic [7:0] OFF_IN        = 8'h08;
    localparam logic [7:0] OFF_INT_EN    = 8'h0C;
    localparam logic [7:0] OFF_INT_TYPE  = 8'h10;
    localparam logic [7:0] OFF_INT_POL   = 8'h14;
    localparam logic [7:0] OFF_INT_BOTH  = 8'h18;
    localparam logic [7:0] OFF_INT_PEND  = 8'h1C;
    localparam logic [7:0] OFF_INT_CLR   = 8'h20;
    localparam logic [7:0] OFF_OUT_SET   = 8'h24;
    localparam logic [7:0] OFF_OUT_CLR   = 8'h28;
    localparam logic [7:0] OFF_OUT_TGL   = 8'h2C;
    localparam logic [7:0] OFF_DB_CYCLES = 8'h30;

    logic            win_hit;
    logic            wr_en;
    logic [7:0]      off;
    logic            unused_wdata;

    logic [NUM_BIDIR-1:0] dir_q, dir_d;
    logic [OUTW-1:0]      out_q, out_d;
    logic [INW-1:0]       int_en_q, int_en_d;
    logic [INW-1:0]       int_type_q, int_type_d;
    logic [INW-1:0]       int_pol_q, int_pol_d;
    logic [INW-1:0]       int_both_q, int_both_d;
    logic [INW-1:0]       pend_q, pend_d;
    logic [INW-1:0]       sync1_q, sync2_q;
    logic [INW-1:0]       prev_q;
    logic [INW-1:0]       filt;
    logic [INW-1:0]       clr_mask;
    logic [INW-1:0]       edge_evt, lvl_act, evt;
    logic [31:0]          db_rd;

    assign win_hit      = (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign wr_en        = mem_we & win_hit;
    assign off          = mem_addr[7:0];
    assign unused_wdata = ^mem_wdata;

    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        int_both_d = int_both_q;
        clr_mask   = '0;
        if (wr_en) begin
            case (off)
                OFF_DIR:      dir_d      = mem_wdata[NUM_BIDIR-1:0];
                OFF_OUT:      out_d      = mem_wdata[OUTW-1:0];
                OFF_INT_EN:   int_en_d   = mem_wdata[INW-1:0];
                OFF_INT_TYPE: int_type_d = mem_wdata[INW-1:0];
                OFF_INT_POL:  int_pol_d  = mem_wdata[INW-1:0];
                OFF_INT_BOTH: int_both_d = mem_wdata[INW-1:0];
                OFF_INT_CLR:  clr_mask   = mem_wdata[INW-1:0];
                OFF_OUT_SET:  out_d      = out_q | mem_wdata[OUTW-1:0];
                OFF_OUT_CLR:  out_d      = out_q & ~mem_wdata[OUTW-1:0];
                OFF_OUT_TGL:  out_d      = out_q ^ mem_wdata[OUTW-1:0];
                default:      ;
            endcase
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_WIDTH-1:0] db_cycles_q;
    logic [DB_WIDTH-1:0] cnt_q [INW];
    logic [INW-1:0]      filt_q;

    // Counter runs only while the synced pin disagrees with the filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cycles_q <= '0;
            filt_q      <= '0;
            for (int i = 0; i < INW; i++) cnt_q[i] <= '0;
        end else begin
            if (wr_en && off == OFF_DB_CYCLES) db_cycles_q <= mem_wdata[DB_WIDTH-1:0];
            for (int i = 0; i < INW; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= db_cycles_q) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign filt  = filt_q;
    assign db_rd = 32'(db_cycles_q);
`else
    assign filt  = sync2_q;
    assign db_rd = '0;
`endif

    // Polarity bit inverts the active sense for both level and single-edge modes.
    assign lvl_act  = filt ^ int_pol_q;
    assign edge_evt = (filt ^ prev_q) & (int_both_q | lvl_act);
    assign evt      = int_en_q & ((int_type_q & lvl_act) | (~int_type_q & edge_evt));

    // Edge events beat a simultaneous clear; level clears hold for one cycle.
    assign pend_d = (pend_q & ~clr_mask) | (evt & ~(clr_mask & int_type_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_both_q <= '0;
            pend_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_both_q <= int_both_d;
            pend_q     <= pend_d;
            sync1_q    <= {gpio_in, gpio_bidir_in};
            sync2_q    <= sync1_q;
            prev_q     <= filt;
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re && win_hit) begin
            case (off)
                OFF_DIR:       mem_rdata = 32'(dir_q);
                OFF_OUT:       mem_rdata = 32'(out_q);
                OFF_IN:        mem_rdata = 32'(filt);
                OFF_INT_EN:    mem_rdata = 32'(int_en_q);
                OFF_INT_TYPE:  mem_rdata = 32'(int_type_q);
                OFF_INT_POL:   mem_rdata = 32'(int_pol_q);
                OFF_INT_BOTH:  mem_rdata = 32'(int_both_q);
                OFF_INT_PEND:  mem_rdata = 32'(pend_q);
                OFF_DB_CYCLES: mem_rdata = db_rd;
                default:       mem_rdata = '0;
            endcase
        end
    end

    assign gpio_bidir_oe  = dir_q;
    assign gpio_bidir_out = out_q[NUM_BIDIR-1:0];
    assign gpio_out       = out_q[OUTW-1:NUM_BIDIR];
    assign gpio_interrupt = |(int_en_q & pend_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;

    localparam logic [31:0] BASE = 32'h4000_1000;
`ifdef GPIO_DEBOUNCE_EN
    localparam int FLT_LAT = 3;
`else
    localparam int FLT_LAT = 2;
`endif

    localparam logic [7:0] A_DIR = 8'h00, A_OUT = 8'h04, A_IN = 8'h08, A_EN = 8'h0C;
    localparam logic [7:0] A_TYPE = 8'h10, A_POL = 8'h14, A_BOTH = 8'h18, A_PEND = 8'h1C;
    localparam logic [7:0] A_CLR = 8'h20, A_SET = 8'h24, A_OCLR = 8'h28, A_TGL = 8'h2C;
    localparam logic [7:0] A_DB = 8'h30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_rdata;
    logic [3:0]  gpio_bidir_in = '0;
    logic [3:0]  gpio_bidir_out;
    logic [3:0]  gpio_bidir_oe;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = '0;
    logic        gpio_interrupt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    gpio_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_rdata      (mem_rdata),
        .gpio_bidir_in  (gpio_bidir_in),
        .gpio_bidir_out (gpio_bidir_out),
        .gpio_bidir_oe  (gpio_bidir_oe),
        .gpio_out       (gpio_out),
        .gpio_in        (gpio_in),
        .gpio_interrupt (gpio_interrupt)
    );

    always #5 clk = ~clk;

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb.push_back('{tag, exp});
        compare(obs);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        mem_addr  = BASE | 32'(off);
        mem_wdata = d;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we    = 1'b0;
    endtask

    task automatic rd_raw(input logic [31:0] addr, input logic re, input logic [31:0] exp,
                          input string tag);
        sb.push_back('{tag, exp});
        mem_addr = addr;
        mem_re   = re;
        #2;
        compare(mem_rdata);
        mem_re = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        rd_raw(BASE | 32'(off), 1'b1, exp, tag);
    endtask

    initial begin
        // Reset values while rst_n is still low
        #3;
        chk("rst_oe", 32'(gpio_bidir_oe), 0);
        chk("rst_bout", 32'(gpio_bidir_out), 0);
        chk("rst_out", 32'(gpio_out), 0);
        chk("rst_irq", 32'(gpio_interrupt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        rd(A_DIR, 0, "rst_dir");
        rd(A_OUT, 0, "rst_outreg");
        rd(A_PEND, 0, "rst_pend");

        // Output set/clear/toggle
        wr(A_DIR, 32'h0000_000F);
        chk("oe_dir", 32'(gpio_bidir_oe), 32'hF);
        wr(A_DIR, 32'hFFFF_FFF5);
        rd(A_DIR, 32'h5, "dir_trunc");
        wr(A_DIR, 0);
        wr(A_OUT, 32'h0F0);
        wr(A_SET, 32'h001);
        wr(A_OCLR, 32'h010);
        wr(A_TGL, 32'h100);
        rd(A_OUT, 32'h1E1, "out_sct");
        chk("pin_bout", 32'(gpio_bidir_out), 32'h1);
        chk("pin_out", 32'(gpio_out), 32'h1E);
        wr(A_SET, 32'hFFFF_F000);
        rd(A_OUT, 32'h1E1, "out_set_upper");

        // Input read, bidir pins in the LSBs
        gpio_in = 8'hA5;
        gpio_bidir_in = 4'h3;
        tick(FLT_LAT + 1);
        rd(A_IN, 32'hA53, "in_read");
        gpio_in = 0;
        gpio_bidir_in = 0;
        tick(FLT_LAT + 1);
        rd(A_IN, 0, "in_zero");

        // Falling-edge interrupt on pin0, irq latency, masking and clear
        wr(A_POL, 32'h1);
        wr(A_EN, 32'h1);
        gpio_bidir_in = 4'h1;
        tick(FLT_LAT + 2);
        rd(A_PEND, 0, "rise_ignored");
        gpio_bidir_in = 4'h0;
        tick(FLT_LAT);
        chk("irq_before", 32'(gpio_interrupt), 0);
        tick(1);
        chk("irq_set", 32'(gpio_interrupt), 1);
        rd(A_PEND, 32'h1, "fall_pend");
        wr(A_EN, 0);
        chk("irq_masked", 32'(gpio_interrupt), 0);
        rd(A_PEND, 32'h1, "pend_kept");
        wr(A_EN, 32'h1);
        chk("irq_unmasked", 32'(gpio_interrupt), 1);
        wr(A_CLR, 32'h1);
        chk("irq_cleared", 32'(gpio_interrupt), 0);
        rd(A_PEND, 0, "pend_cleared");

        // Both-edge mode on pin2
        wr(A_BOTH, 32'h4);
        wr(A_EN, 32'h5);
        gpio_bidir_in = 4'h4;
        tick(FLT_LAT + 1);
        rd(A_PEND, 32'h4, "both_rise");
        wr(A_CLR, 32'h4);
        rd(A_PEND, 0, "both_clr");
        gpio_bidir_in = 4'h0;
        tick(FLT_LAT + 1);
        rd(A_PEND, 32'h4, "both_fall");
        wr(A_CLR, 32'h4);

        // Level-high mode on pin1: clear lasts a single cycle
        wr(A_EN, 0);
        wr(A_BOTH, 0);
        wr(A_TYPE, 32'h2);
        wr(A_EN, 32'h2);
        gpio_bidir_in = 4'h2;
        tick(FLT_LAT + 1);
        rd(A_PEND, 32'h2, "lvl_pend");
        chk("lvl_irq", 32'(gpio_interrupt), 1);
        wr(A_CLR, 32'h2);
        rd(A_PEND, 0, "lvl_clr_cycle");
        rd(A_PEND, 32'h2, "lvl_reassert");
        gpio_bidir_in = 4'h0;
        tick(FLT_LAT + 1);
        wr(A_CLR, 32'h2);
        rd(A_PEND, 0, "lvl_gone");
        wr(A_TYPE, 0);

        // Edge coincident with INT_CLR of the same bit keeps pend
        wr(A_EN, 0);
        wr(A_BOTH, 32'h8);
        wr(A_EN, 32'h8);
        gpio_bidir_in = 4'h8;
        tick(FLT_LAT + 1);
        rd(A_PEND, 32'h8, "p3_rise");
        gpio_bidir_in = 4'h0;
        tick(FLT_LAT);
        wr(A_CLR, 32'h8);
        rd(A_PEND, 32'h8, "edge_vs_clr");
        wr(A_CLR, 32'h8);
        rd(A_PEND, 0, "p3_clr");

        // Zero-returning reads
        rd(8'h34, 0, "unmapped_34");
        rd(A_CLR, 0, "wo_clr");
        rd(A_SET, 0, "wo_set");
        rd(A_TGL, 0, "wo_tgl");
        rd_raw(BASE + 32'h1004, 1'b1, 0, "window_miss");
        rd_raw(BASE | 32'(A_OUT), 1'b0, 0, "re_low");
        rd(A_OUT, 32'h1E1, "out_still");

        // Debounce
        wr(A_DB, 32'h4);
`ifdef GPIO_DEBOUNCE_EN
        rd(A_DB, 32'h4, "db_reg");
        gpio_in = 8'h01;
        tick(3);
        gpio_in = 8'h00;
        for (int i = 0; i < 8; i++) rd(A_IN, 0, "glitch");
        gpio_in = 8'h01;
        tick(6);
        rd(A_IN, 0, "db_early");
        rd(A_IN, 32'h10, "db_seen");
        gpio_in = 8'h00;
        tick(12);
        rd(A_IN, 0, "db_release");
`else
        rd(A_DB, 0, "db_absent");
`endif

        // Reset mid-debounce with pend set
        wr(A_DIR, 32'hA);
        gpio_bidir_in = 4'h8;
        tick(FLT_LAT + 1);
        chk("pre_rst_irq", 32'(gpio_interrupt), 1);
        gpio_in = 8'h01;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("arst_irq", 32'(gpio_interrupt), 0);
        chk("arst_oe", 32'(gpio_bidir_oe), 0);
        chk("arst_out", 32'(gpio_out), 0);
        rd(A_PEND, 0, "arst_pend");
        rst_n = 1'b1;
        tick(FLT_LAT + 6);
        rd(A_IN, 32'h018, "post_rst_in");
        rd(A_PEND, 0, "post_rst_pend");
        chk("post_rst_irq", 32'(gpio_interrupt), 0);
        rd(A_DIR, 0, "post_rst_dir");

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
